// File: rtl/spi_temp_pkg.sv
// Shared types and constants for the BeMicro-SDK temperature sensor SPI master.
package spi_temp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_t;

    localparam int FRAME_BITS = 16;

endpackage

// File: rtl/clk_div_tick.sv
// Modulo-N counter with synchronous restart; tick is high on the terminal count cycle.
module clk_div_tick #(
    parameter int N = 25
) (
    input  logic clk,
    input  logic rstN,
    input  logic restart,
    output logic tick
);

    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(N - 1));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_temp_ctrl.sv
// SPI read sequencer for the temperature sensor: on request or poll tick, clocks in one
// 16-bit frame and publishes it through a holding register with a one-cycle valid strobe.
module spi_temp_ctrl
    import spi_temp_pkg::*;
#(
    parameter int CLK_DIV     = 25,
    parameter int POLL_PERIOD = 5_000_000
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  start,
    input  logic                  enable,
    output logic                  spi_sck,
    output logic                  spi_csN,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic [FRAME_BITS-1:0] temp,
    output logic                  temp_valid,
    output logic                  busy
);

    state_t                state;
    logic                  pending;
    logic [FRAME_BITS-1:0] shift;
    logic [4:0]            bit_cnt;
    logic                  div_tick;
    logic                  poll_tick;

    // Every non-idle state lasts one full prescaler period, so the wrap doubles as the restart.
    clk_div_tick #(.N(CLK_DIV)) u_sck_div (
        .clk     (clk),
        .rstN    (rstN),
        .restart (state == IDLE),
        .tick    (div_tick)
    );

    clk_div_tick #(.N(POLL_PERIOD)) u_poll_div (
        .clk     (clk),
        .rstN    (rstN),
        .restart (!enable),
        .tick    (poll_tick)
    );

    assign spi_mosi = 1'b0;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= IDLE;
            pending    <= 1'b0;
            shift      <= '0;
            bit_cnt    <= '0;
            temp       <= '0;
            temp_valid <= 1'b0;
            busy       <= 1'b0;
            spi_sck    <= 1'b0;
            spi_csN    <= 1'b1;
        end else begin
            temp_valid <= 1'b0;

            // A request arriving on the same edge that consumes pending merges into it.
            if (state == IDLE && pending) begin
                pending <= 1'b0;
            end else if (start || poll_tick) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pending) begin
                        state   <= SETUP;
                        spi_csN <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                SETUP: begin
                    if (div_tick) begin
                        state   <= HIGH;
                        spi_sck <= 1'b1;
                        shift   <= {shift[FRAME_BITS-2:0], spi_miso};
                        bit_cnt <= 5'd1;
                    end else begin
                        bit_cnt <= '0;
                    end
                end
                HIGH: begin
                    if (div_tick) begin
                        state   <= LOW;
                        spi_sck <= 1'b0;
                    end
                end
                LOW: begin
                    if (div_tick) begin
                        if (bit_cnt < 5'(FRAME_BITS)) begin
                            state   <= HIGH;
                            spi_sck <= 1'b1;
                            shift   <= {shift[FRAME_BITS-2:0], spi_miso};
                            bit_cnt <= bit_cnt + 5'd1;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (div_tick) begin
                        state      <= GAP;
                        spi_csN    <= 1'b1;
                        temp       <= shift;
                        temp_valid <= 1'b1;
                    end
                end
                GAP: begin
                    if (div_tick) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_temp_ctrl.sv
// Directed bench: a CLK_DIV=25 instance for frame timing/reset cases and a CLK_DIV=4,
// POLL_PERIOD=2000 instance for periodic polling, each fed by a simple sensor model.
module tb_spi_temp_ctrl;

    logic clk = 1'b0;
    logic rstN = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start_a = 1'b0, enable_a = 1'b0;
    logic        sck_a, csn_a, mosi_a, miso_a, valid_a, busy_a;
    logic [15:0] temp_a;
    logic [15:0] frame_a = 16'h0000;
    logic [4:0]  idx_a = 5'd0;

    logic        start_b = 1'b0, enable_b = 1'b0;
    logic        sck_b, csn_b, mosi_b, miso_b, valid_b, busy_b;
    logic [15:0] temp_b;
    logic [15:0] frame_b = 16'h5A3C;
    logic [4:0]  idx_b = 5'd0;

    spi_temp_ctrl #(.CLK_DIV(25), .POLL_PERIOD(5_000_000)) dut (
        .clk(clk), .rstN(rstN), .start(start_a), .enable(enable_a),
        .spi_sck(sck_a), .spi_csN(csn_a), .spi_mosi(mosi_a), .spi_miso(miso_a),
        .temp(temp_a), .temp_valid(valid_a), .busy(busy_a)
    );

    spi_temp_ctrl #(.CLK_DIV(4), .POLL_PERIOD(2000)) dut_poll (
        .clk(clk), .rstN(rstN), .start(start_b), .enable(enable_b),
        .spi_sck(sck_b), .spi_csN(csn_b), .spi_mosi(mosi_b), .spi_miso(miso_b),
        .temp(temp_b), .temp_valid(valid_b), .busy(busy_b)
    );

    // Sensor presents the MSB when selected and advances on each falling SCK.
    always @(negedge csn_a) idx_a = 5'd0;
    always @(negedge sck_a) if (!csn_a && !idx_a[4]) idx_a = idx_a + 5'd1;
    assign miso_a = idx_a[4] ? 1'b0 : frame_a[4'd15 - idx_a[3:0]];

    always @(negedge csn_b) idx_b = 5'd0;
    always @(negedge sck_b) if (!csn_b && !idx_b[4]) idx_b = idx_b + 5'd1;
    assign miso_b = idx_b[4] ? 1'b0 : frame_b[4'd15 - idx_b[3:0]];

    typedef struct {
        logic [15:0] frame;
        logic [15:0] exp_temp;
        int          exp_latency;
        int          exp_cs_low;
        int          exp_rises;
    } vec_t;

    vec_t vecs[4];

    int          m_latency, m_cs_low, m_rises, m_bad, m_valids, m_falls, m_gap, m_mosi;
    logic [15:0] m_temp;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Pulses start on instance A and records frame timing over a fixed window of cycles.
    task automatic apply_stimulus(input logic [15:0] frame, input bit extra_starts, input int window);
        logic prev_cs, prev_sck;
        int   high_run, sck_run;
        frame_a = frame;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        m_latency = -1; m_cs_low = 0; m_rises = 0; m_bad = 0;
        m_valids = 0; m_falls = 0; m_gap = -1; m_mosi = 0; m_temp = 16'hxxxx;
        prev_cs = csn_a; prev_sck = sck_a; high_run = 0; sck_run = 0;
        for (int k = 1; k <= window; k++) begin
            @(negedge clk);
            start_a = extra_starts && (k == 100 || k == 200 || k == 300);
            if (!csn_a) begin
                m_cs_low++;
                if (prev_cs) begin
                    m_falls++;
                    if (m_falls == 2) m_gap = high_run;
                end
                high_run = 0;
            end else begin
                high_run++;
            end
            if (sck_a) begin
                sck_run++;
                if (!prev_sck) m_rises++;
            end else if (prev_sck) begin
                if (sck_run != 25) m_bad++;
                sck_run = 0;
            end
            if (valid_a) begin
                m_valids++;
                if (m_valids == 1) m_latency = k;
                m_temp = temp_a;
            end
            if (mosi_a) m_mosi++;
            prev_cs = csn_a;
            prev_sck = sck_a;
        end
        start_a = 1'b0;
    endtask

    task automatic wait_valid_b(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            @(negedge clk);
            if (valid_b) at = cyc;
        end
    endtask

    initial begin
        int idle_bad, idle_valids, found, prev, rises;
        int c0, v1, v2, v3, target, cnt, pos, falls, pcs;

        vecs[0] = '{16'hA5C3, 16'hA5C3, 851, 850, 16};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 851, 850, 16};
        vecs[2] = '{16'h0000, 16'h0000, 851, 850, 16};
        vecs[3] = '{16'h8001, 16'h8001, 851, 850, 16};

        #1 rstN = 1'b0;
        repeat (3) @(negedge clk);
        rstN = 1'b1;

        idle_bad = 0; idle_valids = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (valid_a || valid_b) idle_valids++;
            if (!csn_a || sck_a || mosi_a || busy_a || !csn_b || sck_b) idle_bad++;
        end
        check_output("idle_csn", csn_a, 1);
        check_output("idle_sck", sck_a, 0);
        check_output("idle_mosi", mosi_a, 0);
        check_output("idle_temp", temp_a, 0);
        check_output("idle_busy", busy_a, 0);
        check_output("idle_valid_pulses", idle_valids, 0);
        check_output("idle_pin_violations", idle_bad, 0);

        for (int v = 0; v < 4; v++) begin
            apply_stimulus(vecs[v].frame, 1'b0, 1000);
            check_output($sformatf("v%0d_temp", v), m_temp, vecs[v].exp_temp);
            check_output($sformatf("v%0d_latency", v), m_latency, vecs[v].exp_latency);
            check_output($sformatf("v%0d_cs_low", v), m_cs_low, vecs[v].exp_cs_low);
            check_output($sformatf("v%0d_sck_pulses", v), m_rises, vecs[v].exp_rises);
            check_output($sformatf("v%0d_bad_widths", v), m_bad, 0);
            check_output($sformatf("v%0d_valid_count", v), m_valids, 1);
            check_output($sformatf("v%0d_mosi_high", v), m_mosi, 0);
            check_output($sformatf("v%0d_temp_hold", v), temp_a, vecs[v].exp_temp);
        end

        apply_stimulus(16'h0F0F, 1'b1, 2200);
        check_output("b2b_transactions", m_falls, 2);
        check_output("b2b_valid_count", m_valids, 2);
        check_output("b2b_cs_high_gap", m_gap, 26);
        check_output("b2b_sck_pulses", m_rises, 32);
        check_output("b2b_cs_low", m_cs_low, 1700);
        check_output("b2b_temp", m_temp, 16'h0F0F);

        frame_a = 16'hBEEF;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        found = 0; prev = 0; rises = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            @(negedge clk);
            if (sck_a && prev == 0) rises++;
            prev = int'(sck_a);
            if (rises == 8) found = 1;
        end
        check_output("rst_reached_8th_high", found, 1);
        repeat (5) @(negedge clk);
        #3 rstN = 1'b0;
        #1;
        check_output("rst_async_csn", csn_a, 1);
        check_output("rst_async_sck", sck_a, 0);
        check_output("rst_async_temp", temp_a, 0);
        check_output("rst_async_valid", valid_a, 0);
        check_output("rst_async_busy", busy_a, 0);
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        apply_stimulus(16'h1234, 1'b0, 1000);
        check_output("post_rst_temp", m_temp, 16'h1234);
        check_output("post_rst_latency", m_latency, 851);
        check_output("post_rst_valid_count", m_valids, 1);

        @(negedge clk);
        enable_b = 1'b1;
        c0 = cyc;
        wait_valid_b(2500, v1);
        check_output("poll_first_offset", v1 - c0, 2137);
        check_output("poll_temp", temp_b, 16'h5A3C);
        wait_valid_b(2500, v2);
        check_output("poll_interval_1", v2 - v1, 2000);
        wait_valid_b(2500, v3);
        check_output("poll_interval_2", v3 - v2, 2000);

        target = v3 + 1862;
        for (int i = 0; i < 3000 && cyc < target; i++) @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cnt = 0; pos = -1; falls = 0; pcs = 1;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (valid_b) begin
                cnt++;
                pos = cyc;
            end
            if (!csn_b && pcs == 1) falls++;
            pcs = int'(csn_b);
        end
        check_output("coinc_valid_count", cnt, 1);
        check_output("coinc_valid_pos", pos - v3, 2000);
        check_output("coinc_transactions", falls, 1);

        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            @(negedge clk);
            if (!csn_b) found = 1;
        end
        check_output("disable_saw_inflight", found, 1);
        enable_b = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (valid_b) cnt++;
        end
        check_output("disable_valid_count", cnt, 1);
        check_output("disable_idle_busy", busy_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
